layer_4_maxpool2x2: RTL and testbench
=====================================

Name: layer_4_maxpool2x2

Overview:
- Sits directly downstream of a layer-4 feature-map stage.
- Consumes that stage's raster-order stream of FP32 pixels, one feature map per instance.
- Performs 2x2 max-pooling with stride 2 and emits an (IMG_SIZE/2)x(IMG_SIZE/2) stream for the next layer.
- Streaming only: one line buffer, no frame storage, no backpressure.

Parameters:
- DATA_WIDTH, 32: pixel width; IEEE-754 single precision.
- IMG_SIZE, 104: input width and height in pixels. Must be even and >= 2.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  input pixel, raster order (row-major, column 0 first).
- valid_in  input  1  data_in is valid this cycle.
- data_out  output  DATA_WIDTH  pooled pixel.
- valid_out  output  1  data_out is valid this cycle; one-cycle pulse per pooled pixel.
- frame_done  output  1  present only with MAXPOOL_FRAME_DONE_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous, Rst=1):
  - col=0, row=0, hold register=0.
  - data_out=0, valid_out=0, frame_done=0.
  - Line buffer contents are don't-care; they are never read before being written in the same frame.
- Counters:
  - col and row advance only on cycles with valid_in=1.
  - col wraps IMG_SIZE-1 -> 0 and increments row.
  - row wraps IMG_SIZE-1 -> 0, which starts the next frame with no idle cycle required.
  - Gaps in valid_in are allowed anywhere and freeze all state.
- Horizontal stage, on a valid pixel:
  - col even: hold <= data_in.
  - col odd: h = fmax(hold, data_in).
- Vertical stage, at col odd:
  - row even: linebuf[col>>1] <= h. No output.
  - row odd: data_out <= fmax(linebuf[col>>1], h) and valid_out <= 1 on the next clock edge.
- Latency: valid_out asserts exactly 1 cycle after the valid_in that delivers the bottom-right pixel of a window. Otherwise valid_out=0.
- Output holding: data_out holds its last value while valid_out=0.
- Line buffer: IMG_SIZE/2 entries x DATA_WIDTH. Write and read use the same address in mutually exclusive rows, so no read/write collision occurs.
- fmax(a,b), combinational, sign-magnitude compare on raw bits:
  - sign(a)=0 and sign(b)=1 -> a.
  - sign(a)=1 and sign(b)=0 -> b.
  - both sign 0 -> larger unsigned magnitude [30:0].
  - both sign 1 -> smaller unsigned magnitude.
  - Equal bit patterns -> a.
  - +0 and -0 -> the sign-0 operand wins (follows from the rules above).
  - NaN/Inf receive no special handling; they are ordered by raw bits as above.
- Output count: exactly (IMG_SIZE/2)^2 outputs per frame, in raster order.
- Reset mid-frame: the partial frame is discarded. The first valid pixel after Rst deasserts is treated as (row 0, col 0). No spurious valid_out is produced.

Optional Feature:
- Macro: MAXPOOL_FRAME_DONE_EN.
- Defined:
  - frame_done port exists.
  - frame_done pulses high for 1 cycle, coincident with the valid_out of the last pooled pixel (input row IMG_SIZE-1, col IMG_SIZE-1).
  - frame_done resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package yolo_pkg:
  - FP32 field constants: SIGN_BIT=31, MAG_MSB=30.
  - DATA_WIDTH default.
  - Function or constant for the pooled size IMG_SIZE/2.
- Sub-module fp32_max: purely combinational, inputs a,b, output y, implementing the fmax rules above.
  - Two instances: horizontal and vertical.
  - Reusable by later maxpool layers.

Test Plan (IMG_SIZE=4 unless noted):
- Ramp: pixels 1.0..16.0 (0x3F800000...) fed back-to-back -> outputs 6.0, 8.0, 14.0, 16.0 in order. Each valid_out fires 1 cycle after input pixel indices 5, 7, 13, 15 respectively.
- Sign handling: window {-1.0, -2.0, -3.0, -0.5} -> -0.5 (0xBF000000). Window {+0 (0x00000000), -0 (0x80000000), -1.0, -2.0} -> 0x00000000.
- Gapped input: same ramp as the first test with valid_in toggled 1/0 each cycle -> identical output values. Each output still 1 cycle after its window's last valid input.
- Back-to-back frames: two ramps with no gap -> 8 outputs, the second frame identical to the first. With MAXPOOL_FRAME_DONE_EN, frame_done pulses exactly twice, aligned with outputs 4 and 8.
- Reset mid-frame: assert Rst after 9 pixels, then send a full ramp -> exactly 4 outputs (6, 8, 14, 16) and no valid_out during or right after reset.
- Default size: IMG_SIZE=104 random FP32 frame compared against a reference model -> 2704 outputs matching bit-exactly.

Source files
------------

// File: rtl/yolo_pkg.sv
// Shared constants and helpers for the YOLO feature-map pipeline.
// Provides FP32 field positions, the default pixel width and the pooled-size helper.
package yolo_pkg;

    localparam int unsigned SIGN_BIT           = 31;
    localparam int unsigned MAG_MSB            = 30;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef struct packed {
        logic                sign;
        logic [MAG_MSB:0]    mag;
    } fp32_t;

    // Output side length of a 2x2 / stride-2 pool.
    function automatic int unsigned pooled_size(input int unsigned img_size);
        return img_size / 2;
    endfunction

endpackage

// File: rtl/fp32_max.sv
// Combinational FP32 maximum on raw bits (sign-magnitude order, no NaN/Inf special cases).
// Ties and +0/-0 resolve toward operand a or the sign-0 operand respectively.
module fp32_max
    import yolo_pkg::*;
(
    input  logic [SIGN_BIT:0] a,
    input  logic [SIGN_BIT:0] b,
    output logic [SIGN_BIT:0] y
);

    fp32_t fa;
    fp32_t fb;

    assign fa = fp32_t'(a);
    assign fb = fp32_t'(b);

    always_comb begin
        y = a;
        if (fa.sign != fb.sign) begin
            y = fa.sign ? b : a;
        end else if (!fa.sign) begin
            y = (fb.mag > fa.mag) ? b : a;
        end else begin
            // Both negative: the smaller magnitude is the larger value.
            y = (fb.mag < fa.mag) ? b : a;
        end
    end

endmodule

// File: rtl/layer_4_maxpool2x2.sv
// Streaming 2x2 / stride-2 FP32 max-pool with a single half-width line buffer.
// Define MAXPOOL_FRAME_DONE_EN to add the frame_done pulse on the last pooled pixel.
module layer_4_maxpool2x2
    import yolo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned IMG_SIZE   = 104
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
`ifdef MAXPOOL_FRAME_DONE_EN
    ,
    output logic                  frame_done
`endif
);

    localparam int unsigned HALF = pooled_size(IMG_SIZE);
    localparam int unsigned CW   = $clog2(IMG_SIZE) + 1;
    localparam int unsigned AW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] linebuf [HALF];
    logic [DATA_WIDTH-1:0] h_max;
    logic [DATA_WIDTH-1:0] v_max;
    logic [AW-1:0]         lb_addr;
    logic                  last_col;
    logic                  last_row;
    logic                  frame_done_q;

    assign last_col = (col == CW'(IMG_SIZE - 1));
    assign last_row = (row == CW'(IMG_SIZE - 1));
    assign lb_addr  = AW'(col >> 1);

    fp32_max u_hmax (
        .a (hold),
        .b (data_in),
        .y (h_max)
    );

    fp32_max u_vmax (
        .a (linebuf[lb_addr]),
        .b (h_max),
        .y (v_max)
    );

    // Raster counters, horizontal hold register and registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            col          <= '0;
            row          <= '0;
            hold         <= '0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            valid_out    <= 1'b0;
            frame_done_q <= 1'b0;
            if (valid_in) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end

                if (!col[0]) begin
                    hold <= data_in;
                end else if (row[0]) begin
                    data_out     <= v_max;
                    valid_out    <= 1'b1;
                    frame_done_q <= last_row && last_col;
                end
            end
        end
    end

    // Even rows park their horizontal maxima for the odd row below.
    always_ff @(posedge Clk) begin
        if (valid_in && col[0] && !row[0]) begin
            linebuf[lb_addr] <= h_max;
        end
    end

`ifdef MAXPOOL_FRAME_DONE_EN
    assign frame_done = frame_done_q;
`else
    logic unused_fd;
    assign unused_fd = frame_done_q;
`endif

endmodule

// File: tb/tb_layer_4_maxpool2x2.sv
// Directed bench for layer_4_maxpool2x2: a 4x4 instance for directed cases
// and a 104x104 instance checked against an ordered-key reference model.
module tb_layer_4_maxpool2x2;

    localparam int unsigned BIG   = 104;
    localparam int unsigned BHALF = BIG / 2;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst;
    logic [31:0] din;
    logic        vin;
    logic [31:0] dout;
    logic        vout;
    logic        fd;

    logic        rst_b;
    logic [31:0] din_b;
    logic        vin_b;
    logic [31:0] dout_b;
    logic        vout_b;
    logic        fd_b;

    layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(4)) dut (
        .Clk       (Clk),
        .Rst       (rst),
        .data_in   (din),
        .valid_in  (vin),
        .data_out  (dout),
        .valid_out (vout)
`ifdef MAXPOOL_FRAME_DONE_EN
        ,
        .frame_done(fd)
`endif
    );

    layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(BIG)) dut_big (
        .Clk       (Clk),
        .Rst       (rst_b),
        .data_in   (din_b),
        .valid_in  (vin_b),
        .data_out  (dout_b),
        .valid_out (vout_b)
`ifdef MAXPOOL_FRAME_DONE_EN
        ,
        .frame_done(fd_b)
`endif
    );

`ifndef MAXPOOL_FRAME_DONE_EN
    assign fd   = 1'b0;
    assign fd_b = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] out_q [$];
    int          tag_q [$];
    bit          fd_q  [$];
    int          fd_cnt;
    int          prev_idx;
    int          pix_idx;

    logic [31:0] ramp  [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                                32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    logic [31:0] exp_r [4]  = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    int          exp_t [4]  = '{5, 7, 13, 15};
    // Row0: -1 -2 +0 -0 / Row1: -3 -0.5 -1 -2 / Rows 2-3: 1..8
    logic [31:0] sgn   [16] = '{32'hBF800000, 32'hC0000000, 32'h00000000, 32'h80000000,
                                32'hC0400000, 32'hBF000000, 32'hBF800000, 32'hC0000000,
                                32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] exp_s [4]  = '{32'hBF000000, 32'h00000000, 32'h40C00000, 32'h41000000};

    logic [31:0] img   [BIG*BIG];
    logic [31:0] pexp  [BHALF*BHALF];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Sample outputs of the previous edge, then drive the next input.
    task automatic step(input bit v, input logic [31:0] d);
        @(negedge Clk);
        if (vout) begin
            out_q.push_back(dout);
            tag_q.push_back(prev_idx);
            fd_q.push_back(fd);
        end
        if (fd) fd_cnt++;
        vin = v;
        din = v ? d : 32'hDEADBEEF;
        if (v) begin
            prev_idx = pix_idx;
            pix_idx++;
        end else begin
            prev_idx = -1;
        end
    endtask

    task automatic clear_log();
        out_q.delete();
        tag_q.delete();
        fd_q.delete();
        fd_cnt   = 0;
        pix_idx  = 0;
        prev_idx = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic check_ramp(input string pfx);
        check({pfx, "_count"}, 32'(out_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < out_q.size(); k++) begin
            check($sformatf("%s_val%0d", pfx, k), out_q[k], exp_r[k]);
            check($sformatf("%s_lat%0d", pfx, k), 32'(tag_q[k]), 32'(exp_t[k]));
        end
    endtask

    function automatic logic [31:0] okey(input logic [31:0] x);
        return x[31] ? {1'b0, ~x[30:0]} : {1'b1, x[30:0]};
    endfunction

    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
        return (okey(b) > okey(a)) ? b : a;
    endfunction

    initial begin
        rst   = 1'b1;
        vin   = 1'b0;
        din   = 32'h0;
        rst_b = 1'b1;
        vin_b = 1'b0;
        din_b = 32'h0;
        clear_log();
        repeat (2) @(negedge Clk);
        check("rst_data_out", dout, 32'h0);
        check("rst_valid_out", 32'(vout), 32'h0);
        check("rst_frame_done", 32'(fd), 32'h0);
        rst   = 1'b0;
        rst_b = 1'b0;

        // Back-to-back ramp
        clear_log();
        for (int i = 0; i < 16; i++) step(1'b1, ramp[i]);
        idle(3);
        check_ramp("ramp");

        // Sign handling
        clear_log();
        for (int i = 0; i < 16; i++) step(1'b1, sgn[i]);
        idle(3);
        check("sign_count", 32'(out_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < out_q.size(); k++)
            check($sformatf("sign_val%0d", k), out_q[k], exp_s[k]);

        // Gapped input
        clear_log();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, ramp[i]);
            step(1'b0, 32'h0);
        end
        idle(3);
        check_ramp("gap");

        // Two frames with no gap
        clear_log();
        for (int i = 0; i < 32; i++) step(1'b1, ramp[i % 16]);
        idle(3);
        check("b2b_count", 32'(out_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            check($sformatf("b2b_val%0d", k), out_q[k], exp_r[k % 4]);
            check($sformatf("b2b_lat%0d", k), 32'(tag_q[k]), 32'(exp_t[k % 4] + 16 * (k / 4)));
`ifdef MAXPOOL_FRAME_DONE_EN
            check($sformatf("b2b_fd%0d", k), 32'(fd_q[k]), 32'((k % 4) == 3));
`endif
        end
`ifdef MAXPOOL_FRAME_DONE_EN
        check("b2b_fd_count", 32'(fd_cnt), 32'd2);
`endif

        // Reset after 9 pixels, then a full ramp
        clear_log();
        for (int i = 0; i < 9; i++) step(1'b1, ramp[i]);
        for (int j = 0; j < 3; j++) begin
            @(negedge Clk);
            check($sformatf("midrst_vout%0d", j), 32'(vout), 32'h0);
            vin = 1'b0;
            rst = (j < 2);
        end
        clear_log();
        for (int i = 0; i < 16; i++) step(1'b1, ramp[i]);
        idle(3);
        check_ramp("midrst");

        // Full-size random frame against the reference model
        for (int i = 0; i < BIG * BIG; i++) begin
            case ($urandom_range(0, 15))
                0:       img[i] = 32'h00000000;
                1:       img[i] = 32'h80000000;
                2:       img[i] = (i > 0) ? img[i-1] : 32'h3F800000;
                default: img[i] = $urandom;
            endcase
        end
        for (int r = 0; r < BHALF; r++) begin
            for (int c = 0; c < BHALF; c++) begin
                pexp[r*BHALF + c] = ref_max(
                    ref_max(img[(2*r)*BIG + 2*c],   img[(2*r)*BIG + 2*c + 1]),
                    ref_max(img[(2*r+1)*BIG + 2*c], img[(2*r+1)*BIG + 2*c + 1]));
            end
        end
        begin
            int oi;
            int fdb;
            oi  = 0;
            fdb = 0;
            for (int i = 0; i < BIG * BIG + 4; i++) begin
                @(negedge Clk);
                if (vout_b) begin
                    if (oi < BHALF * BHALF)
                        check($sformatf("big_out%0d", oi), dout_b, pexp[oi]);
                    oi++;
                end
                if (fd_b) begin
                    fdb++;
`ifdef MAXPOOL_FRAME_DONE_EN
                    check("big_fd_pos", 32'(oi), 32'(BHALF * BHALF));
`endif
                end
                vin_b = (i < BIG * BIG);
                din_b = (i < BIG * BIG) ? img[i] : 32'h0;
            end
            check("big_count", 32'(oi), 32'(BHALF * BHALF));
`ifdef MAXPOOL_FRAME_DONE_EN
            check("big_fd_count", 32'(fdb), 32'd1);
`else
            check("big_fd_count", 32'(fdb), 32'd0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
